// File: rtl/mem_arb_rsp_demux_if.sv
// Bundle for the arbiter read-return bus and the per-user response ports of mem_arb_rsp_demux.
// With MEM_ARB_RSP_CNT_EN defined, the bundle also carries the per-user pop counters (rsp_cnt).
interface mem_arb_rsp_demux_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int N  = 2,
    parameter int D  = 4
);
    localparam int LW = $clog2(D) + 1;

    logic [N-1:0]          i_v;
    logic [AW-1:0]         i_a;
    logic [DW-1:0]         i_d;
    logic [N-1:0]          o_v;
    logic [N-1:0]          o_rdy;
    logic [N-1:0][AW-1:0]  o_a;
    logic [N-1:0][DW-1:0]  o_d;
    logic [N-1:0][LW-1:0]  lvl;
    logic [N-1:0]          ovf;
    logic [N-1:0]          ovf_clr;
`ifdef MEM_ARB_RSP_CNT_EN
    logic [N-1:0][31:0]    rsp_cnt;

    // The master side is the arbiter plus the users. The slave side is the demux.
    modport master (
        output i_v, i_a, i_d, o_rdy, ovf_clr,
        input  o_v, o_a, o_d, lvl, ovf, rsp_cnt
    );
    modport slave (
        input  i_v, i_a, i_d, o_rdy, ovf_clr,
        output o_v, o_a, o_d, lvl, ovf, rsp_cnt
    );
`else
    modport master (
        output i_v, i_a, i_d, o_rdy, ovf_clr,
        input  o_v, o_a, o_d, lvl, ovf
    );
    modport slave (
        input  i_v, i_a, i_d, o_rdy, ovf_clr,
        output o_v, o_a, o_d, lvl, ovf
    );
`endif
endinterface

// File: rtl/mem_arb_rsp_demux.sv
// Steers the arbiter's one-hot read returns into per-user show-ahead FIFOs, with sticky overflow flags.
// Optional MEM_ARB_RSP_CNT_EN adds per-user 32-bit pop counters on bus.rsp_cnt.
module mem_arb_rsp_demux #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int N  = 2,
    parameter int D  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_arb_rsp_demux_if.slave    bus
);
    localparam int PW = $clog2(D);
    localparam int EW = AW + DW;

    logic [N-1:0] push;
    logic [N-1:0] pop;
    logic [N-1:0] full;
    logic [N-1:0] empty;
    logic [N-1:0] drop;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_user
            logic [EW-1:0] mem [D];
            logic [PW:0]   wptr_reg;
            logic [PW:0]   rptr_reg;
            logic          ovf_reg;
            logic [EW-1:0] head;

            // The extra wrap bit tells full apart from empty when the index bits match.
            assign empty[gi] = (wptr_reg == rptr_reg);
            assign full[gi]  = ((wptr_reg ^ rptr_reg) == {1'b1, {PW{1'b0}}});
            assign pop[gi]   = !empty[gi] && bus.o_rdy[gi];
            assign push[gi]  = bus.i_v[gi] && (!full[gi] || pop[gi]);
            assign drop[gi]  = bus.i_v[gi] && full[gi] && !pop[gi];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wptr_reg[PW-1:0]] <= {bus.i_a, bus.i_d};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                end else begin
                    if (push[gi]) begin
                        wptr_reg <= wptr_reg + (PW+1)'(1);
                    end
                    if (pop[gi]) begin
                        rptr_reg <= rptr_reg + (PW+1)'(1);
                    end
                end
            end

            // When drop and clear happen in the same cycle, the drop wins.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    ovf_reg <= 1'b0;
                end else if (drop[gi]) begin
                    ovf_reg <= 1'b1;
                end else if (bus.ovf_clr[gi]) begin
                    ovf_reg <= 1'b0;
                end
            end

            // Show-ahead head. It is forced to zero while empty, so o_a/o_d read 0 after reset.
            assign head          = mem[rptr_reg[PW-1:0]];
            assign bus.o_v[gi]   = !empty[gi];
            assign bus.o_a[gi]   = empty[gi] ? '0 : head[EW-1:DW];
            assign bus.o_d[gi]   = empty[gi] ? '0 : head[DW-1:0];
            assign bus.lvl[gi]   = wptr_reg - rptr_reg;
            assign bus.ovf[gi]   = ovf_reg;

`ifdef MEM_ARB_RSP_CNT_EN
            logic [31:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (pop[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            assign bus.rsp_cnt[gi] = cnt_reg;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_mem_arb_rsp_demux.sv
// Self-checking bench for mem_arb_rsp_demux. It runs directed scenarios, then randomized traffic
// against a queue-based reference model.
module tb_mem_arb_rsp_demux;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 2;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model: one FIFO queue per user, plus the overflow flags and pop counts.
    logic [AW+DW-1:0] mq [N][$];
    logic             m_ovf [N];
    logic [31:0]      m_cnt [N];

    mem_arb_rsp_demux_if #(.AW(AW), .DW(DW), .N(N), .D(D)) bus ();

    mem_arb_rsp_demux #(.AW(AW), .DW(DW), .N(N), .D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [N-1:0] iv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [N-1:0] rdy, input logic [N-1:0] clr);
        bus.i_v     = iv;
        bus.i_a     = a;
        bus.i_d     = d;
        bus.o_rdy   = rdy;
        bus.ovf_clr = clr;
    endtask

    // Update the model from the current inputs, then advance one clock edge and settle.
    task automatic step();
        bit do_pop;
        bit is_full;
        for (int k = 0; k < N; k++) begin
            if (!rst) begin
                mq[k].delete();
                m_ovf[k] = 1'b0;
                m_cnt[k] = '0;
            end else begin
                do_pop  = (mq[k].size() > 0) && bus.o_rdy[k];
                is_full = (mq[k].size() == D);
                if (do_pop) void'(mq[k].pop_front());
                if (bus.i_v[k] && (!is_full || do_pop)) mq[k].push_back({bus.i_a, bus.i_d});
                if (bus.i_v[k] && is_full && !do_pop) m_ovf[k] = 1'b1;
                else if (bus.ovf_clr[k]) m_ovf[k] = 1'b0;
                if (do_pop) m_cnt[k] = m_cnt[k] + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, '0, '0, '0);
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive('0, '0, '0, '0, '0);
        step();
        step();
        rst = 1'b1;
        checks++;
        if (bus.o_v !== 2'b00 || bus.ovf !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: o_v=%b ovf=%b required 00/00", bus.o_v, bus.ovf);
        end
        checks++;
        if (bus.lvl !== '0 || bus.o_a !== '0 || bus.o_d !== '0) begin
            failures++;
            $display("FAIL reset_data: lvl=%h o_a=%h o_d=%h required all 0", bus.lvl, bus.o_a, bus.o_d);
        end
    endtask

    task automatic test_basic_routing();
        do_reset();
        drive(2'b01, 16'h0010, 16'hBEEF, 2'b00, 2'b00);
        step();
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.o_v !== 2'b01 || bus.o_a[0] !== 16'h0010 || bus.o_d[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL basic_route: o_v=%b o_a0=%h o_d0=%h required 01/0010/beef",
                     bus.o_v, bus.o_a[0], bus.o_d[0]);
        end
        checks++;
        if (bus.lvl[0] !== LW'(1) || bus.lvl[1] !== LW'(0)) begin
            failures++;
            $display("FAIL basic_lvl: lvl0=%0d lvl1=%0d required 1/0", bus.lvl[0], bus.lvl[1]);
        end
    endtask

    task automatic test_order_wrap();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(2'b10, AW'(16'h0100 + i), DW'(i), 2'b10, 2'b00);
            if (i > 1) begin
                checks++;
                if (bus.o_d[1] !== DW'(i - 1)) begin
                    failures++;
                    $display("FAIL order_head: o_d1=%0d required %0d", bus.o_d[1], i - 1);
                end
            end
            step();
            checks++;
            if (bus.lvl[1] !== LW'(1) || bus.ovf !== 2'b00) begin
                failures++;
                $display("FAIL order_lvl: lvl1=%0d ovf=%b required 1/00", bus.lvl[1], bus.ovf);
            end
        end
        drive('0, '0, '0, 2'b10, 2'b00);
        checks++;
        if (bus.o_d[1] !== DW'(10)) begin
            failures++;
            $display("FAIL order_last: o_d1=%0d required 10", bus.o_d[1]);
        end
        step();
        checks++;
        if (bus.o_v !== 2'b00) begin
            failures++;
            $display("FAIL order_drained: o_v=%b required 00", bus.o_v);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(2'b01, '0, DW'(i), 2'b00, 2'b00);
            step();
        end
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.lvl[0] !== LW'(4) || bus.ovf[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: lvl0=%0d ovf0=%b required 4/1", bus.lvl[0], bus.ovf[0]);
        end
        drive('0, '0, '0, 2'b01, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.o_v[0] !== 1'b1 || bus.o_d[0] !== DW'(i)) begin
                failures++;
                $display("FAIL ovf_drain: o_v0=%b o_d0=%0d required 1/%0d", bus.o_v[0], bus.o_d[0], i);
            end
            step();
        end
        checks++;
        if (bus.o_v[0] !== 1'b0 || bus.ovf[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: o_v0=%b ovf0=%b required 0/1", bus.o_v[0], bus.ovf[0]);
        end
        drive('0, '0, '0, 2'b00, 2'b01);
        step();
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.ovf !== 2'b00) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b required 00", bus.ovf);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(2'b01, '0, DW'(i), 2'b00, 2'b00);
            step();
        end
        drive(2'b01, '0, DW'(5), 2'b01, 2'b00);
        step();
        drive('0, '0, '0, 2'b01, 2'b00);
        checks++;
        if (bus.ovf[0] !== 1'b0 || bus.lvl[0] !== LW'(4)) begin
            failures++;
            $display("FAIL fullpop_state: ovf0=%b lvl0=%0d required 0/4", bus.ovf[0], bus.lvl[0]);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (bus.o_d[0] !== DW'(i)) begin
                failures++;
                $display("FAIL fullpop_drain: o_d0=%0d required %0d", bus.o_d[0], i);
            end
            step();
        end
        checks++;
        if (bus.o_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_empty: o_v0=%b required 0", bus.o_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 2'b11 : 2'b01, AW'(i), DW'(16'h0050 + i), 2'b00, 2'b00);
            step();
        end
        drive('0, '0, '0, 2'b00, 2'b00);
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (bus.o_v !== 2'b00 || bus.lvl !== '0 || bus.ovf !== 2'b00) begin
            failures++;
            $display("FAIL midreset: o_v=%b lvl=%h ovf=%b required 00/0/00", bus.o_v, bus.lvl, bus.ovf);
        end
        drive(2'b10, 16'h0001, 16'h00AA, 2'b00, 2'b00);
        step();
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.o_v !== 2'b10 || bus.lvl[1] !== LW'(1) || bus.o_d[1] !== 16'h00AA) begin
            failures++;
            $display("FAIL midreset_push: o_v=%b lvl1=%0d o_d1=%h required 10/1/00aa",
                     bus.o_v, bus.lvl[1], bus.o_d[1]);
        end
    endtask

    task automatic test_set_clear_collision();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(2'b01, '0, DW'(i), 2'b00, 2'b00);
            step();
        end
        drive(2'b01, '0, DW'(9), 2'b00, 2'b01);
        step();
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.ovf[0] !== 1'b1 || bus.lvl[0] !== LW'(4)) begin
            failures++;
            $display("FAIL collision_ovf: ovf0=%b lvl0=%0d required 1/4", bus.ovf[0], bus.lvl[0]);
        end
        drive('0, '0, '0, 2'b01, 2'b00);
        for (int i = 0; i < 3; i++) step();
        drive('0, '0, '0, 2'b00, 2'b00);
        checks++;
        if (bus.lvl[0] !== LW'(1) || bus.o_d[0] !== DW'(4)) begin
            failures++;
            $display("FAIL collision_pops: lvl0=%0d o_d0=%0d required 1/4", bus.lvl[0], bus.o_d[0]);
        end
`ifdef MEM_ARB_RSP_CNT_EN
        checks++;
        if (bus.rsp_cnt[0] !== 32'd3 || bus.rsp_cnt[1] !== 32'd0) begin
            failures++;
            $display("FAIL rsp_cnt: cnt0=%0d cnt1=%0d required 3/0", bus.rsp_cnt[0], bus.rsp_cnt[1]);
        end
`endif
    endtask

    task automatic test_random();
        logic [AW+DW-1:0] exp_head;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), AW'($urandom), DW'($urandom), N'($urandom),
                  ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
            if (c % 97 == 96) rst = 1'b0;
            step();
            rst = 1'b1;
            for (int k = 0; k < N; k++) begin
                checks++;
                if (bus.o_v[k] !== (mq[k].size() != 0) || bus.lvl[k] !== LW'(mq[k].size())
                    || bus.ovf[k] !== m_ovf[k]) begin
                    failures++;
                    $display("FAIL rand_state[%0d] cyc %0d: o_v=%b lvl=%0d ovf=%b required %b/%0d/%b",
                             k, c, bus.o_v[k], bus.lvl[k], bus.ovf[k],
                             mq[k].size() != 0, mq[k].size(), m_ovf[k]);
                end
                if (mq[k].size() != 0) begin
                    exp_head = mq[k][0];
                    checks++;
                    if ({bus.o_a[k], bus.o_d[k]} !== exp_head) begin
                        failures++;
                        $display("FAIL rand_head[%0d] cyc %0d: got %h required %h",
                                 k, c, {bus.o_a[k], bus.o_d[k]}, exp_head);
                    end
                end
`ifdef MEM_ARB_RSP_CNT_EN
                checks++;
                if (bus.rsp_cnt[k] !== m_cnt[k]) begin
                    failures++;
                    $display("FAIL rand_cnt[%0d] cyc %0d: got %0d required %0d",
                             k, c, bus.rsp_cnt[k], m_cnt[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive('0, '0, '0, '0, '0);
        #1;
        test_reset();
        test_basic_routing();
        test_order_wrap();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_set_clear_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arb_rsp_demux.md
Name: mem_arb_rsp_demux

Overview:
- Downstream of the single-port memory arbiter.
- Takes the arbiter's shared read-return bus (one-hot valid vector plus common address and data) and steers each returned word into a per-user response buffer.
- Each user drains its buffer with its own valid/ready handshake, so user back-pressure never stalls the arbiter.
- Drops on a full buffer are reported through sticky per-user overflow flags.

Parameters:
- AW, 16, address width of the returned word.
- DW, 16, data width of the returned word.
- N, 2, number of users / response buffers (N >= 1).
- D, 4, depth of each response buffer in entries; power of 2, D >= 2.

Ports:
- clk  input  1  single clock, shared with the arbiter's RAM side.
- rst  input  1  reset, synchronous, active-low.
- i_v  input  N  return valid from arbiter, one bit per user.
- i_a  input  AW  returned address (shared).
- i_d  input  DW  returned data (shared).
- o_v  output  N  per-user response valid.
- o_rdy  input  N  per-user response ready (pop).
- o_a  output  N*AW  per-user head address, packed [N-1:0][AW-1:0].
- o_d  output  N*DW  per-user head data, packed [N-1:0][DW-1:0].
- lvl  output  N*($clog2(D)+1)  per-user fill level, 0..D.
- ovf  output  N  sticky per-user overflow flag.
- ovf_clr  input  N  per-user overflow clear.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All write/read pointers and levels go to 0.
  - o_v=0, ovf=0.
  - o_a and o_d go to 0.
  - Buffer RAM contents are not cleared.
- Reset mid-operation discards all buffered words; the first push after reset release is accepted normally.
- Each buffer is a circular buffer.
  - Pointers are $clog2(D) bits wide plus one wrap bit.
  - full = (wptr ^ rptr) == {1'b1, 0...}; empty = wptr == rptr.
- Push:
  - On a clk edge with i_v[k]=1, {i_a, i_d} is written to buffer k if it is not full, or if it is full and a pop occurs in the same cycle.
  - i_v is nominally one-hot. If several bits are set, every selected buffer captures the same {i_a, i_d} independently; this is not an error.
- Pop: occurs on a clk edge when o_v[k]=1 and o_rdy[k]=1.
- Outputs:
  - Buffers are show-ahead: o_v[k] = !empty[k], and o_a[k]/o_d[k] always present the head entry.
  - o_a/o_d are driven combinationally from the registered buffer storage.
  - o_a/o_d content is undefined when o_v[k]=0.
- Latency: a word pushed at edge T into an empty buffer gives o_v[k]=1 after edge T (visible in cycle T+1).
- Level: lvl[k] += push - pop each cycle.
  - Simultaneous push and pop leaves lvl unchanged.
  - Push and pop on an empty buffer in the same cycle is impossible, since o_v=0 means no pop.
- Overflow:
  - i_v[k]=1 while full with no same-cycle pop drops the word. Pointers are unchanged and ovf[k] is set at that edge.
  - ovf[k] stays set until ovf_clr[k]=1 at an edge.
  - If the set and clear conditions coincide, set wins.
- Wrap-around: pointers wrap modulo 2*D. Order is strict FIFO per user across the wrap.
- Users are fully independent; activity on buffer j never affects buffer k.

Optional Feature:
- Macro: MEM_ARB_RSP_CNT_EN.
- Defined:
  - Adds output port rsp_cnt, N*32, packed [N-1:0][31:0].
  - Counter k increments by 1 on each pop of buffer k and wraps from 32'hFFFF_FFFF to 0.
  - Reset value is 0. The counters are not affected by ovf_clr.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic routing, N=2, D=4: after reset, i_v=2'b01, i_a=16'h0010, i_d=16'hBEEF, o_rdy=0, for one cycle -> next cycle o_v=2'b01, o_a[0]=16'h0010, o_d[0]=16'hBEEF, lvl[0]=1, lvl[1]=0.
- Order and wrap: push 10 words d=1..10 to user 1 while popping every cycle with o_rdy[1]=1 -> o_d[1] sequence 1..10 in order, ovf=0, lvl[1] never exceeds 1.
- Overflow: o_rdy=0, push 5 words d=1..5 to user 0 -> lvl[0]=4, ovf[0]=1. Draining yields 1,2,3,4 only. ovf[0] stays 1 until ovf_clr[0] is pulsed, then reads 0.
- Full with simultaneous pop: fill user 0 to 4 entries (1..4), then assert i_v[0] with d=5 and o_rdy[0]=1 in the same cycle -> no drop, ovf[0]=0, lvl[0]=4, subsequent drain gives 2,3,4,5.
- Reset mid-operation: user 0 has 3 words and user 1 has 2 words. Drive rst=0 for one edge -> o_v=0, lvl=0, ovf=0. A push of d=16'h00AA to user 1 after release appears as the only entry.
- Set/clear collision, with MEM_ARB_RSP_CNT_EN defined: ovf_clr[0]=1 in the same cycle as an overflow drop -> ovf[0]=1. After 3 pops from user 0 -> rsp_cnt[0]=3, rsp_cnt[1]=0.
